// File: rtl/commit_tracer_pkg.sv
// Shared record layout and type codes for the commit trace stream.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package commit_tracer_pkg;

  // Record kind codes carried in the type field
  localparam logic EV_GRF = 1'b0;
  localparam logic EV_DM  = 1'b1;

  // One record: kind + pc + addr + data
  localparam int REC_W = 1 + 32 + 32 + 32;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  // Builds a record from its fields
  function automatic rec_t mk_rec(input logic        kind,
                                  input logic [31:0] pc,
                                  input logic [31:0] addr,
                                  input logic [31:0] data);
    rec_t r;
    r.kind = kind;
    r.pc   = pc;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

  // Register numbers are zero-extended into the 32-bit address field
  function automatic logic [31:0] grf_addr_ext(input logic [4:0] a);
    return {27'd0, a};
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Record storage for the commit trace FIFO: two write ports, one async read port.
// Latency: writes land on the rising edge; the read port is combinational from raddr.
// Backpressure: none; the owner guarantees the two write addresses never collide.
module trace_fifo_mem
  import commit_tracer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [REC_W-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [REC_W-1:0] wdata1,
  input  logic [AW-1:0]    raddr,
  output logic [REC_W-1:0] rdata
);

  logic [REC_W-1:0] mem [DEPTH];

  // Storage is not reset: an entry is only ever read after it has been written
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  // Head record is read straight from the array
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/commit_tracer.sv
// Captures GRF and DM commit events into a FIFO and streams them out in program order.
// Latency: 1 cycle from capture edge to head when empty; no input-to-output bypass.
// Backpressure: head held while ev_ready=0; events beyond free space are dropped, setting sticky overflow.
module commit_tracer
  import commit_tracer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grf_we,
  input  logic [31:0]              grf_pc,
  input  logic [4:0]               grf_addr,
  input  logic [31:0]              grf_wd,
  input  logic                     dm_we,
  input  logic [31:0]              dm_pc,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_wd,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic                     ev_type,
  output logic [31:0]              ev_pc,
  output logic [31:0]              ev_addr,
  output logic [31:0]              ev_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;

  logic             grf_ev;
  logic             dm_ev;
  logic             deq;
  logic [CW:0]      free;
  logic             grf_acc;
  logic             dm_acc;
  logic             drop;
  logic             we0;
  logic             we1;
  logic [1:0]       n_enq;
  rec_t             grf_rec;
  rec_t             dm_rec;
  rec_t             wr_rec0;
  rec_t             wr_rec1;
  rec_t             head_rec;
  logic [REC_W-1:0] head_raw;
  logic [PW-1:0]    waddr1;

  // Event detection, space check and write-port steering (GRF is older, so it goes first)
  always_comb begin
    grf_ev  = grf_we && (grf_addr != 5'd0);
    dm_ev   = dm_we;
    deq     = (cnt_q != '0) && ev_ready;
    free    = (CW+1)'(DEPTH) - {1'b0, cnt_q} + {{CW{1'b0}}, deq};
    grf_acc = grf_ev && (free >= (CW+1)'(1));
    dm_acc  = dm_ev && (free >= (grf_acc ? (CW+1)'(2) : (CW+1)'(1)));
    drop    = (grf_ev && !grf_acc) || (dm_ev && !dm_acc);

    grf_rec = mk_rec(EV_GRF, grf_pc, grf_addr_ext(grf_addr), grf_wd);
    dm_rec  = mk_rec(EV_DM, dm_pc, dm_addr, dm_wd);

    // Nothing is written while reset is held
    we0     = (grf_acc || dm_acc) && !reset;
    we1     = grf_acc && dm_acc && !reset;
    wr_rec0 = grf_acc ? grf_rec : dm_rec;
    wr_rec1 = dm_rec;
    n_enq   = {1'b0, we0} + {1'b0, we1};
    waddr1  = wr_ptr + PW'(1);
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (wr_ptr),
    .wdata0 (wr_rec0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wr_rec1),
    .raddr  (rd_ptr),
    .rdata  (head_raw)
  );

  // Pointers wrap naturally because DEPTH is a power of two; overflow is sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_enq);
      rd_ptr <= rd_ptr + PW'(deq);
      cnt_q  <= cnt_q + CW'(n_enq) - CW'(deq);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Head fields are masked to zero when empty so reset reads back all-zero without touching storage
  always_comb begin
    head_rec = rec_t'(head_raw);
    ev_valid = (cnt_q != '0);
    ev_type  = ev_valid ? head_rec.kind : 1'b0;
    ev_pc    = ev_valid ? head_rec.pc   : 32'd0;
    ev_addr  = ev_valid ? head_rec.addr : 32'd0;
    ev_data  = ev_valid ? head_rec.data : 32'd0;
    count    = cnt_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_commit_tracer.sv
// Directed self-checking bench for commit_tracer with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised via ev_ready held low to fill, high to drain.
module tb_commit_tracer;

  logic        clk;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_type;
  logic [31:0] ev_pc;
  logic [31:0] ev_addr;
  logic [31:0] ev_data;
  logic [3:0]  count;
  logic        overflow;

  int n_vec;
  int n_miscmp;

  commit_tracer #(.DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .grf_we   (grf_we),
    .grf_pc   (grf_pc),
    .grf_addr (grf_addr),
    .grf_wd   (grf_wd),
    .dm_we    (dm_we),
    .dm_pc    (dm_pc),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_type  (ev_type),
    .ev_pc    (ev_pc),
    .ev_addr  (ev_addr),
    .ev_data  (ev_data),
    .count    (count),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_wd = '0;
    dm_we  = 1'b0; dm_pc  = '0; dm_addr  = '0; dm_wd  = '0;
  endtask

  task automatic drive_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] wd);
    grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wd = wd;
  endtask

  task automatic drive_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] wd);
    dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wd = wd;
  endtask

  logic [31:0] exp_drain [8];

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    reset    = 1'b1;
    ev_ready = 1'b0;
    idle_inputs();

    // Reset state
    step(); step();
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_pc", ev_pc, 0);
    chk("rst_addr", ev_addr, 0);
    chk("rst_data", ev_data, 0);

    // Event during reset is discarded
    drive_grf(32'h2000, 5'd7, 32'h1);
    step();
    chk("rst_discard_count", count, 0);

    // First edge after release captures
    reset = 1'b0;
    idle_inputs();
    drive_grf(32'h3000, 5'd5, 32'h12);
    step();
    idle_inputs();
    chk("first_valid", ev_valid, 1);
    chk("first_type", ev_type, 0);
    chk("first_pc", ev_pc, 32'h3000);
    chk("first_addr", ev_addr, 5);
    chk("first_data", ev_data, 32'h12);
    chk("first_count", count, 1);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("first_drain_count", count, 0);
    chk("first_drain_valid", ev_valid, 0);

    // Write to $0 is ignored without overflow
    drive_grf(32'h3004, 5'd0, 32'hdead);
    step();
    idle_inputs();
    chk("r0_count", count, 0);
    chk("r0_ovf", overflow, 0);

    // Simultaneous GRF+DM: GRF out first
    ev_ready = 1'b1;
    drive_grf(32'h3008, 5'd3, 32'h7);
    drive_dm(32'h300c, 32'h10, 32'h9);
    step();
    idle_inputs();
    chk("sim_count2", count, 2);
    chk("sim_h1_type", ev_type, 0);
    chk("sim_h1_pc", ev_pc, 32'h3008);
    chk("sim_h1_addr", ev_addr, 3);
    chk("sim_h1_data", ev_data, 7);
    step();
    chk("sim_h2_type", ev_type, 1);
    chk("sim_h2_pc", ev_pc, 32'h300c);
    chk("sim_h2_addr", ev_addr, 32'h10);
    chk("sim_h2_data", ev_data, 9);
    chk("sim_count1", count, 1);
    step();
    chk("sim_count0", count, 0);
    // Dequeue on empty is a no-op
    step();
    chk("empty_deq_count", count, 0);
    chk("empty_deq_ovf", overflow, 0);

    // Fill with 8 DM events while stalled
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_dm(32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 32'ha0 + 32'(i));
      step();
    end
    idle_inputs();
    chk("fill_count", count, 8);
    chk("fill_ovf", overflow, 0);
    chk("fill_head", ev_data, 32'ha0);
    step();
    chk("stall_head_stable", ev_data, 32'ha0);

    // 9th event is dropped
    drive_dm(32'h4020, 32'h108, 32'ha8);
    step();
    idle_inputs();
    chk("ovf9_count", count, 8);
    chk("ovf9_flag", overflow, 1);
    chk("ovf9_head", ev_data, 32'ha0);

    // Full plus dequeue with GRF+DM: only one slot, GRF kept
    ev_ready = 1'b1;
    drive_grf(32'h5000, 5'd9, 32'h55);
    drive_dm(32'h5004, 32'h200, 32'h66);
    step();
    idle_inputs();
    ev_ready = 1'b0;
    chk("fulldeq_count", count, 8);
    chk("fulldeq_ovf", overflow, 1);
    chk("fulldeq_head", ev_data, 32'ha1);

    // Drain in order
    for (int i = 0; i < 7; i++) exp_drain[i] = 32'ha1 + 32'(i);
    exp_drain[7] = 32'h55;
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_data%0d", i), ev_data, exp_drain[i]);
      if (i == 7) begin
        chk("drain_last_type", ev_type, 0);
        chk("drain_last_addr", ev_addr, 9);
      end
      step();
    end
    ev_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_valid", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Mid-stream reset clears immediately
    for (int i = 1; i <= 5; i++) begin
      drive_grf(32'h6000 + 32'(4 * i), 5'(i), 32'(i));
      step();
    end
    idle_inputs();
    chk("mid_count5", count, 5);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_data", ev_data, 0);
    step();
    reset = 1'b0;

    // Capture resumes after release
    drive_dm(32'h7000, 32'h300, 32'h77);
    step();
    idle_inputs();
    chk("resume_count", count, 1);
    chk("resume_type", ev_type, 1);
    chk("resume_data", ev_data, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/commit_tracer.md
COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 Parameter DEPTH, default 8, means FIFO entries; power of two, at least 2.
REQ-002 clk  input  1  means the single clock; all state updates on the rising edge.
REQ-003 reset  input  1  means asynchronous, active-high reset.
REQ-004 grf_we  input  1  means the WB stage writes the register file this cycle.
REQ-005 grf_pc  input  32  means the PC of the WB instruction.
REQ-006 grf_addr  input  5  means the destination register number.
REQ-007 grf_wd  input  32  means the register write data.
REQ-008 dm_we  input  1  means the MEM stage writes data memory this cycle.
REQ-009 dm_pc  input  32  means the PC of the MEM instruction.
REQ-010 dm_addr  input  32  means the byte address of the memory write.
REQ-011 dm_wd  input  32  means the memory write data.
REQ-012 ev_valid  output  1  means the head record is presented.
REQ-013 ev_ready  input  1  means the consumer accepts the head record.
REQ-014 ev_type  output  1  means record kind: 0 = GRF, 1 = DM.
REQ-015 ev_pc, ev_addr, ev_data  output  32 each  mean the head record fields; a GRF address is zero-extended from 5 bits.
REQ-016 count  output  $clog2(DEPTH)+1  means the number of occupied entries.
REQ-017 overflow  output  1  means sticky: at least one event was dropped.

Function
REQ-018 The block SHALL capture CPU commit events into a FIFO and present them in order on a valid/ready stream.
REQ-019 A GRF event SHALL be generated only when grf_we=1 and grf_addr!=0; writes to $0 SHALL be ignored silently, without setting overflow.
REQ-020 A DM event SHALL be generated when dm_we=1.
REQ-021 When both events occur in the same cycle, the GRF event (the older instruction) SHALL be enqueued first and the DM event second.
REQ-022 Up to 2 enqueues and 1 dequeue SHALL be supported per cycle.
REQ-023 A dequeue SHALL occur on the edge where ev_valid=1 and ev_ready=1.
REQ-024 Free space SHALL be computed as DEPTH-count+(dequeue this cycle ? 1 : 0).
REQ-025 Events exceeding free space SHALL be dropped and SHALL set overflow on the same edge.
REQ-026 With only one slot free, the GRF event SHALL be kept and the DM event dropped.
REQ-027 Latency SHALL be 1 cycle: an event captured at edge N SHALL be visible at the head after edge N if the FIFO was empty; there SHALL be no combinational input-to-output bypass.
REQ-028 ev_valid SHALL equal (count!=0).
REQ-029 Head fields SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 count SHALL update as count + enqueues - dequeue.
REQ-032 Dequeue on empty SHALL be a no-op.
REQ-033 overflow SHALL clear only on reset.

Reset
REQ-034 Asserting reset SHALL asynchronously clear both pointers, count and overflow, and force ev_valid=0.
REQ-035 On reset, ev_type, ev_pc, ev_addr and ev_data SHALL read 0.
REQ-036 Events presented during reset SHALL be discarded.
REQ-037 Reset asserted mid-stream SHALL discard all buffered records.
REQ-038 Capture SHALL resume at the first rising edge after reset deasserts.

Structure
REQ-039 A shared package SHALL hold the record type constants (EV_GRF=0, EV_DM=1) and the record width (97 bits: type+pc+addr+data).
REQ-040 One sub-module, trace_fifo_mem (a DEPTH x 97 storage array with two write ports and one read port), SHALL hold the entries.
REQ-041 Pointer, count and overflow logic SHALL reside in commit_tracer.

Verification
REQ-042 Reset scenario: reset=1, then grf_we=1, addr=5, pc=0x3000, wd=0x12 on the first edge after release -> next cycle ev_valid=1, type=0, pc=0x3000, addr=5, data=0x12, count=1.
REQ-043 Simultaneous scenario: grf (pc 0x3008, addr 3, wd 7) and dm (pc 0x300c, addr 0x10, wd 9) in one cycle, ev_ready=1 -> GRF record out first, DM record the next cycle.
REQ-044 $0 scenario: grf_we=1, grf_addr=0 -> count unchanged, overflow=0.
REQ-045 Fill scenario: ev_ready=0, 8 single events, then a 9th -> count=8, overflow=1, head still the 1st event; drain 8 -> data in order, count=0.
REQ-046 Full plus dequeue scenario: count=8, ev_ready=1, simultaneous GRF+DM -> GRF kept, DM dropped, overflow=1, count stays 8.
REQ-047 Mid-stream reset scenario: assert reset with count=5 -> ev_valid=0 and count=0 immediately, without waiting for a clock edge.
